// File: rtl/odometer_bf_meas_multi_pkg.sv
// Shared types and defaults for the multi-channel beat-frequency measurement engine.
// The FSM encoding and the channel-index width helper live here.
package odometer_bf_meas_multi_pkg;

   localparam int DEF_NUM_CH     = 4;
   localparam int DEF_CNT_W      = 12;
   localparam int DEF_DZ_CYC     = 8;
   localparam int DEF_SETTLE_CYC = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_SETTLE = 3'd2,
      ST_ARM    = 3'd3,
      ST_COUNT  = 3'd4,
      ST_STORE  = 3'd5,
      ST_DONE   = 3'd6
   } state_e;

   // A single channel still needs a 1-bit index.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/odometer_bf_meas_multi_if.sv
// Control/result bundle of the beat-frequency engine. The master side drives
// trigger, mask and the stressed oscillators; the slave side is the engine.
interface odometer_bf_meas_multi_if
   import odometer_bf_meas_multi_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CNT_W  = DEF_CNT_W
) ();

   logic                    MEAS_TRIG;
   logic [NUM_CH-1:0]       CH_EN;
   logic [NUM_CH-1:0]       ROSC_STRESS;
   logic                    MEAS_STRESS;
   logic                    BUSY;
   logic [NUM_CH-1:0]       EN_ROSC;
   logic                    MEAS_DONE;
   logic [NUM_CH*CNT_W-1:0] BF_COUNT;
   logic [NUM_CH-1:0]       BF_VALID;
   logic [NUM_CH-1:0]       BF_OVF;

   modport master (
      output MEAS_TRIG, CH_EN, ROSC_STRESS,
      input  MEAS_STRESS, BUSY, EN_ROSC, MEAS_DONE, BF_COUNT, BF_VALID, BF_OVF
   );

   modport slave (
      input  MEAS_TRIG, CH_EN, ROSC_STRESS,
      output MEAS_STRESS, BUSY, EN_ROSC, MEAS_DONE, BF_COUNT, BF_VALID, BF_OVF
   );

endinterface

// File: rtl/odometer_bf_meas_multi_pc_filter.sv
// Phase-compare front end: 2-flop synchroniser, high-run counter and the
// deadzone-qualified falling-edge pulse. clr_i flushes everything synchronously.
module odometer_bf_meas_multi_pc_filter
   import odometer_bf_meas_multi_pkg::*;
#(
   parameter int DZ_CYC = DEF_DZ_CYC
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic raw_i,
   output logic edge_o
);

   localparam int              HI_W   = $clog2(DZ_CYC + 1);
   localparam logic [HI_W-1:0] HI_SAT = HI_W'(DZ_CYC);

   logic            sync_q, sync_d;
   logic            pc_q, pc_d;
   logic [HI_W-1:0] hi_cnt_q, hi_cnt_d;

   // hi_cnt_q holds the run of ones ending on the previous pc sample.
   always_comb begin
      sync_d   = raw_i;
      pc_d     = sync_q;
      hi_cnt_d = '0;
      if (pc_q) begin
         hi_cnt_d = (hi_cnt_q == HI_SAT) ? hi_cnt_q : hi_cnt_q + 1'b1;
      end
      if (clr_i) begin
         sync_d   = 1'b0;
         pc_d     = 1'b0;
         hi_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q   <= 1'b0;
         pc_q     <= 1'b0;
         hi_cnt_q <= '0;
      end else begin
         sync_q   <= sync_d;
         pc_q     <= pc_d;
         hi_cnt_q <= hi_cnt_d;
      end
   end

   assign edge_o = !clr_i && !pc_q && (hi_cnt_q == HI_SAT);

endmodule

// File: rtl/odometer_bf_meas_multi.sv
// Multi-channel beat-frequency sweep: on a trigger, each enabled stressed ROSC
// is enabled, settled, phase-compared against ROSC_REF and one beat period counted.
module odometer_bf_meas_multi
   import odometer_bf_meas_multi_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int DZ_CYC     = DEF_DZ_CYC,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
   input  logic                    ROSC_REF,
   input  logic                    RESETB,
   odometer_bf_meas_multi_if.slave meas_if
);

   localparam int               CH_IDX_W    = idx_w(NUM_CH);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] TMO_LAST    = CNT_MAX - 1'b1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   state_e                  state_q, state_d;
   logic                    trig_q;
   logic                    trig_rise;
   logic [NUM_CH-1:0]       pend_q, pend_d;
   logic [CH_IDX_W-1:0]     ch_q, ch_d;
   logic [CNT_W-1:0]        beat_q, beat_d;
   logic                    ovf_flag_q, ovf_flag_d;
   logic [NUM_CH*CNT_W-1:0] count_q, count_d;
   logic [NUM_CH-1:0]       valid_q, valid_d;
   logic [NUM_CH-1:0]       ovf_q, ovf_d;
   logic                    sel_found;
   logic [CH_IDX_W-1:0]     sel_idx;
   logic                    pc_clr;
   logic                    pc_raw;
   logic                    pc_edge;

   assign trig_rise = meas_if.MEAS_TRIG & ~trig_q;
   assign pc_clr    = !(state_q inside {ST_ARM, ST_COUNT});
   assign pc_raw    = meas_if.ROSC_STRESS[ch_q];

   // One filter serves every channel; it is flushed whenever the channel changes.
   odometer_bf_meas_multi_pc_filter #(
      .DZ_CYC (DZ_CYC)
   ) u_pc_filter (
      .clk_i  (ROSC_REF),
      .rst_ni (RESETB),
      .clr_i  (pc_clr),
      .raw_i  (pc_raw),
      .edge_o (pc_edge)
   );

   // Lowest pending channel wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (pend_q[k]) begin
            sel_found = 1'b1;
            sel_idx   = CH_IDX_W'(k);
         end
      end
   end

   always_ff @(posedge ROSC_REF or negedge RESETB) begin
      if (!RESETB) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (trig_rise) state_d = ST_SELECT;
         ST_SELECT: state_d = sel_found ? ST_SETTLE : ST_DONE;
         ST_SETTLE: if (beat_q == SETTLE_LAST) state_d = ST_ARM;
         ST_ARM: begin
            if (pc_edge)                state_d = ST_COUNT;
            else if (beat_q == TMO_LAST) state_d = ST_STORE;
         end
         ST_COUNT:  if (pc_edge || beat_q == CNT_MAX) state_d = ST_STORE;
         ST_STORE:  state_d = ST_SELECT;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // beat_q doubles as settle timer, arm timeout and beat counter.
   always_comb begin
      pend_d     = pend_q;
      ch_d       = ch_q;
      beat_d     = beat_q;
      ovf_flag_d = ovf_flag_q;
      count_d    = count_q;
      valid_d    = valid_q;
      ovf_d      = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (trig_rise) begin
               pend_d  = meas_if.CH_EN;
               count_d = '0;
               valid_d = '0;
               ovf_d   = '0;
            end
         end
         ST_SELECT: begin
            if (sel_found) begin
               ch_d       = sel_idx;
               beat_d     = '0;
               ovf_flag_d = 1'b0;
            end
         end
         ST_SETTLE: begin
            beat_d = (beat_q == SETTLE_LAST) ? '0 : beat_q + 1'b1;
         end
         ST_ARM: begin
            if (pc_edge) begin
               beat_d = '0;
            end else if (beat_q == TMO_LAST) begin
               beat_d     = CNT_MAX;
               ovf_flag_d = 1'b1;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         ST_COUNT: begin
            // An edge on the terminal cycle is a real measurement, held at all-ones.
            if (pc_edge) begin
               if (beat_q != CNT_MAX) beat_d = beat_q + 1'b1;
            end else if (beat_q == CNT_MAX) begin
               ovf_flag_d = 1'b1;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         ST_STORE: begin
            count_d[ch_q*CNT_W +: CNT_W] = beat_q;
            valid_d[ch_q]                = 1'b1;
            ovf_d[ch_q]                  = ovf_flag_q;
            pend_d[ch_q]                 = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge ROSC_REF or negedge RESETB) begin
      if (!RESETB) begin
         trig_q     <= 1'b0;
         pend_q     <= '0;
         ch_q       <= '0;
         beat_q     <= '0;
         ovf_flag_q <= 1'b0;
         count_q    <= '0;
         valid_q    <= '0;
         ovf_q      <= '0;
      end else begin
         trig_q     <= meas_if.MEAS_TRIG;
         pend_q     <= pend_d;
         ch_q       <= ch_d;
         beat_q     <= beat_d;
         ovf_flag_q <= ovf_flag_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
      end
   end

   always_comb begin
      meas_if.BUSY        = (state_q != ST_IDLE);
      meas_if.MEAS_STRESS = !(state_q inside {ST_IDLE, ST_DONE});
      meas_if.MEAS_DONE   = (state_q == ST_DONE);
      meas_if.EN_ROSC     = '0;
      if (state_q inside {ST_SETTLE, ST_ARM, ST_COUNT}) begin
         meas_if.EN_ROSC = NUM_CH'(1) << ch_q;
      end
   end

   assign meas_if.BF_COUNT = count_q;
   assign meas_if.BF_VALID = valid_q;
   assign meas_if.BF_OVF   = ovf_q;

endmodule

// File: tb/tb_odometer_bf_meas_multi.sv
// Directed bench for odometer_bf_meas_multi: synthetic stressed-ROSC waveforms
// driven in ROSC_REF cycles, results compared against hand-derived beat periods.
module tb_odometer_bf_meas_multi;

   localparam int NCH = 4;
   localparam int CW  = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   odometer_bf_meas_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

   odometer_bf_meas_multi #(
      .NUM_CH     (NCH),
      .CNT_W      (CW),
      .DZ_CYC     (8),
      .SETTLE_CYC (16)
   ) dut (
      .ROSC_REF (clk),
      .RESETB   (rst_n),
      .meas_if  (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Waveform modes: 0 square of period[k], 1 stuck high, 2 150-cycle beat with 3-cycle glitch.
   int mode[NCH]   = '{0, 0, 0, 0};
   int period[NCH] = '{100, 200, 300, 400};
   int cyc = 0;

   always @(negedge clk) begin
      logic [NCH-1:0] w;
      int ph;
      cyc++;
      ph = cyc % 150;
      for (int k = 0; k < NCH; k++) begin
         case (mode[k])
            0:       w[k] = (cyc % period[k]) < (period[k] / 2);
            1:       w[k] = 1'b1;
            default: w[k] = (ph < 75) || (ph >= 100 && ph < 103);
         endcase
      end
      bus.ROSC_STRESS = w;
   end

   int             done_cnt = 0;
   int             en_cnt   = 0;
   int             bad_oh   = 0;
   logic [NCH-1:0] en_log[64];
   logic [NCH-1:0] last_en  = '0;

   always @(negedge clk) begin
      if (bus.MEAS_DONE === 1'b1) done_cnt++;
      if ($countones(bus.EN_ROSC) > 1 || (bus.BUSY !== 1'b1 && bus.EN_ROSC != 0) ||
          (bus.MEAS_DONE === 1'b1 && bus.EN_ROSC != 0)) bad_oh++;
      if (bus.EN_ROSC != 0 && bus.EN_ROSC != last_en && en_cnt < 64) begin
         en_log[en_cnt] = bus.EN_ROSC;
         en_cnt++;
      end
      last_en = bus.EN_ROSC;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CW-1:0] cnt(input int k);
      return bus.BF_COUNT[k*CW +: CW];
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic trig();
      bus.MEAS_TRIG = 1'b1;
      @(negedge clk);
      bus.MEAS_TRIG = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int n;
      n = 0;
      while (bus.MEAS_DONE !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", {63'd0, bus.MEAS_DONE}, 64'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},   {63'd0, bus.BUSY},        64'd0);
      chk({tag, "_stress"}, {63'd0, bus.MEAS_STRESS}, 64'd0);
      chk({tag, "_done"},   {63'd0, bus.MEAS_DONE},   64'd0);
      chk({tag, "_en"},     {60'd0, bus.EN_ROSC},     64'd0);
      chk({tag, "_count"},  {16'd0, bus.BF_COUNT},    64'd0);
      chk({tag, "_valid"},  {60'd0, bus.BF_VALID},    64'd0);
      chk({tag, "_ovf"},    {60'd0, bus.BF_OVF},      64'd0);
   endtask

   task automatic chk_full(input string tag);
      chk({tag, "_c0"},    {52'd0, cnt(0)}, 64'd100);
      chk({tag, "_c1"},    {52'd0, cnt(1)}, 64'd200);
      chk({tag, "_c2"},    {52'd0, cnt(2)}, 64'd300);
      chk({tag, "_c3"},    {52'd0, cnt(3)}, 64'd400);
      chk({tag, "_valid"}, {60'd0, bus.BF_VALID}, 64'hF);
      chk({tag, "_ovf"},   {60'd0, bus.BF_OVF},   64'h0);
   endtask

   int d0, e0;

   initial begin
      bus.MEAS_TRIG = 1'b0;
      bus.CH_EN     = '0;
      rst_n         = 1'b0;
      tick(3);
      chk_all_zero("rst");
      rst_n = 1'b1;
      tick(2);

      // Empty mask: SELECT then DONE, pulse two cycles after acceptance.
      bus.CH_EN = 4'b0000;
      d0 = done_cnt;
      e0 = en_cnt;
      trig();
      chk("empty_busy",   {63'd0, bus.BUSY},        64'd1);
      chk("empty_stress", {63'd0, bus.MEAS_STRESS}, 64'd1);
      chk("empty_early",  {63'd0, bus.MEAS_DONE},   64'd0);
      tick(1);
      chk("empty_done",   {63'd0, bus.MEAS_DONE},   64'd1);
      chk("empty_stress_off", {63'd0, bus.MEAS_STRESS}, 64'd0);
      tick(1);
      chk("empty_done_off", {63'd0, bus.MEAS_DONE}, 64'd0);
      chk("empty_idle",     {63'd0, bus.BUSY},      64'd0);
      chk("empty_valid",    {60'd0, bus.BF_VALID},  64'd0);
      tick(1);
      chk("empty_no_en",    en_cnt - e0,            1'b0 ? 64'd1 : 64'd0);
      chk("empty_pulses",   done_cnt - d0,          64'd1);

      // Full sweep, with a second trigger pulse while busy.
      bus.CH_EN = 4'b1111;
      d0 = done_cnt;
      e0 = en_cnt;
      trig();
      tick(500);
      trig();
      wait_done(20000);
      tick(2);
      chk_full("full");
      chk("full_en_steps", en_cnt - e0, 64'd4);
      chk("full_en_seq", {48'd0, en_log[e0+3], en_log[e0+2], en_log[e0+1], en_log[e0]}, 64'h8421);
      chk("full_pulses", done_cnt - d0, 64'd1);
      chk("full_idle", {63'd0, bus.BUSY}, 64'd0);

      // Sparse mask; a mask change during the sweep must not matter.
      bus.CH_EN = 4'b0101;
      e0 = en_cnt;
      trig();
      tick(50);
      bus.CH_EN = 4'b1111;
      wait_done(20000);
      tick(2);
      chk("mask_c0",    {52'd0, cnt(0)}, 64'd100);
      chk("mask_c1",    {52'd0, cnt(1)}, 64'd0);
      chk("mask_c2",    {52'd0, cnt(2)}, 64'd300);
      chk("mask_c3",    {52'd0, cnt(3)}, 64'd0);
      chk("mask_valid", {60'd0, bus.BF_VALID}, 64'h5);
      chk("mask_en_seq", {56'd0, en_log[e0+1], en_log[e0]}, 64'h41);

      // Stuck-high channel 0 times out; channel 1 still measured.
      mode[0]   = 1;
      bus.CH_EN = 4'b0011;
      trig();
      wait_done(20000);
      tick(2);
      chk("tmo_c0",    {52'd0, cnt(0)}, 64'hFFF);
      chk("tmo_c1",    {52'd0, cnt(1)}, 64'd200);
      chk("tmo_ovf",   {60'd0, bus.BF_OVF},   64'h1);
      chk("tmo_valid", {60'd0, bus.BF_VALID}, 64'h3);

      // Short glitches are below the deadzone and rejected.
      mode[0]   = 2;
      bus.CH_EN = 4'b0001;
      trig();
      wait_done(20000);
      tick(2);
      chk("glitch_c0",    {52'd0, cnt(0)}, 64'd150);
      chk("glitch_ovf",   {60'd0, bus.BF_OVF},   64'h0);
      chk("glitch_valid", {60'd0, bus.BF_VALID}, 64'h1);

      // Reset in the middle of channel 1, then a clean sweep.
      mode[0]   = 0;
      bus.CH_EN = 4'b1111;
      trig();
      begin
         int n;
         n = 0;
         while (bus.EN_ROSC !== 4'b0010 && n < 5000) begin
            @(negedge clk);
            n++;
         end
      end
      chk("mid_reach_ch1", {60'd0, bus.EN_ROSC}, 64'h2);
      tick(100);
      chk("mid_valid", {60'd0, bus.BF_VALID}, 64'h1);
      chk("mid_c0",    {52'd0, cnt(0)},       64'd100);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);
      trig();
      wait_done(20000);
      tick(2);
      chk_full("after_rst");

      chk("en_onehot", bad_oh, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
